greenhouse_climate_ctrl: RTL and testbench

//   Downstream consumer of the i2c_control sensor outputs: samples the four temperatures and four lux

---
 rtl/climate_pkg.sv | 21 ++
 rtl/greenhouse_climate_ctrl_if.sv | 37 +++
 rtl/lux_shade_hyst.sv | 48 ++++
 rtl/greenhouse_climate_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_greenhouse_climate_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/climate_pkg.sv
// Shared types and constants for the greenhouse climate controller.
package climate_pkg;

    localparam int unsigned TEMP_WIDTH = 9;
    localparam int T_MIN = -40;
    localparam int T_MAX = 85;

    typedef logic signed [TEMP_WIDTH-1:0] temp_t;
    typedef logic signed [TEMP_WIDTH:0]   temp_ext_t;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StHeating = 2'b01,
        StCooling = 2'b10
    } ctrl_state_e;

    function automatic temp_ext_t sext(input temp_t t);
        return {t[TEMP_WIDTH-1], t};
    endfunction

endpackage

// File: rtl/greenhouse_climate_ctrl_if.sv
// Sensor readings in from i2c_control and actuator commands out to the I/O drivers.
interface greenhouse_climate_ctrl_if;
    import climate_pkg::*;

    temp_t       solar_celcius;
    temp_t       greenhouse_celcius;
    temp_t       ambient_celcius;
    temp_t       geothermal_celcius;
    logic [15:0] n_lux;
    logic [15:0] e_lux;
    logic [15:0] s_lux;
    logic [15:0] w_lux;

    logic        heater_on;
    logic        geo_pump_on;
    logic        vent_open;
    logic        fan_on;
    logic        shade_closed;
    logic        solar_pump_on;
    logic        sensor_fault;
    logic [1:0]  ctrl_state;

    modport master (
        output solar_celcius, greenhouse_celcius, ambient_celcius, geothermal_celcius,
        output n_lux, e_lux, s_lux, w_lux,
        input  heater_on, geo_pump_on, vent_open, fan_on, shade_closed, solar_pump_on,
        input  sensor_fault, ctrl_state
    );

    modport slave (
        input  solar_celcius, greenhouse_celcius, ambient_celcius, geothermal_celcius,
        input  n_lux, e_lux, s_lux, w_lux,
        output heater_on, geo_pump_on, vent_open, fan_on, shade_closed, solar_pump_on,
        output sensor_fault, ctrl_state
    );

endinterface

// File: rtl/lux_shade_hyst.sv
// Averages four lux readings and drives the shade with a hi/lo hysteresis band.
module lux_shade_hyst #(
    parameter int unsigned LUX_HI = 30000,
    parameter int unsigned LUX_LO = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] n_lux,
    input  logic [15:0] e_lux,
    input  logic [15:0] s_lux,
    input  logic [15:0] w_lux,
    output logic        shade_closed
);

    localparam logic [15:0] LuxHi = 16'(LUX_HI);
    localparam logic [15:0] LuxLo = 16'(LUX_LO);

    logic [17:0] lux_sum;
    logic [15:0] lux_avg;
    logic        shade_d;
    logic        shade_q;

    // 18-bit sum keeps four full-scale readings without overflow.
    always_comb begin
        lux_sum = 18'(n_lux) + 18'(e_lux) + 18'(s_lux) + 18'(w_lux);
        lux_avg = lux_sum[17:2];
        shade_d = shade_q;
        if (en) begin
            if (lux_avg > LuxHi) begin
                shade_d = 1'b1;
            end else if (lux_avg < LuxLo) begin
                shade_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shade_q <= 1'b0;
        end else begin
            shade_q <= shade_d;
        end
    end

    assign shade_closed = shade_q;

endmodule

// File: rtl/greenhouse_climate_ctrl.sv
// Periodic sampling of greenhouse sensors, hysteretic heat/cool FSM with minimum dwell,
// sensor-fault gating and registered actuator outputs.
module greenhouse_climate_ctrl
    import climate_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = 1000,
    parameter int          SETPOINT    = 22,
    parameter int          HYST        = 2,
    parameter int unsigned MIN_DWELL   = 3,
    parameter int          GEO_DELTA   = 2,
    parameter int          SOLAR_DELTA = 5,
    parameter int unsigned LUX_HI      = 30000,
    parameter int unsigned LUX_LO      = 20000
) (
    input  logic                      clk,
    input  logic                      rst,
    greenhouse_climate_ctrl_if.slave  bus
);

    localparam int unsigned CntW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DwellW = $clog2(MIN_DWELL + 2);

    localparam logic [CntW-1:0]   CntLast    = CntW'(SAMPLE_DIV - 1);
    localparam logic [DwellW-1:0] DwellMin   = DwellW'(MIN_DWELL);
    localparam temp_ext_t         Setpoint   = temp_ext_t'(SETPOINT);
    localparam temp_ext_t         HeatOn     = temp_ext_t'(SETPOINT - HYST);
    localparam temp_ext_t         CoolOn     = temp_ext_t'(SETPOINT + HYST);
    localparam temp_ext_t         GeoDelta   = temp_ext_t'(GEO_DELTA);
    localparam temp_ext_t         SolarDelta = temp_ext_t'(SOLAR_DELTA);
    localparam temp_ext_t         TMin       = temp_ext_t'(T_MIN);
    localparam temp_ext_t         TMax       = temp_ext_t'(T_MAX);

    logic [CntW-1:0]   cnt_q;
    logic              tick;
    logic              eval_q;

    temp_t             solar_q, gh_q, amb_q, geo_q;
    logic [15:0]       n_lux_q, e_lux_q, s_lux_q, w_lux_q;

    ctrl_state_e       state_q, state_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic              heater_q, heater_d;
    logic              geo_q_on, geo_d_on;
    logic              vent_q, vent_d;
    logic              fan_q, fan_d;
    logic              fault_q, fault_d;
    logic              solar_on_q, solar_on_d;
    logic              shade;

    temp_ext_t         gh;
    logic              fault;

    assign tick = (cnt_q == CntLast);

    always_comb begin
        gh         = sext(gh_q);
        fault      = (gh < TMin) || (gh > TMax);
        state_d    = state_q;
        dwell_d    = dwell_q;
        heater_d   = heater_q;
        geo_d_on   = geo_q_on;
        vent_d     = vent_q;
        fan_d      = fan_q;
        fault_d    = fault_q;
        solar_on_d = solar_on_q;
        if (eval_q) begin
            fault_d    = fault;
            solar_on_d = sext(solar_q) > (gh + SolarDelta);
            heater_d   = 1'b0;
            geo_d_on   = 1'b0;
            vent_d     = 1'b0;
            fan_d      = 1'b0;
            if (fault) begin
                state_d = StIdle;
                dwell_d = '0;
            end else begin
                if (dwell_q >= DwellMin) begin
                    case (state_q)
                        StIdle: begin
                            if (gh < HeatOn) begin
                                state_d = StHeating;
                            end else if (gh > CoolOn) begin
                                state_d = StCooling;
                            end
                        end
                        StHeating: if (gh >= Setpoint) state_d = StIdle;
                        StCooling: if (gh <= Setpoint) state_d = StIdle;
                        default:   state_d = StIdle;
                    endcase
                end
                if (state_d != state_q) begin
                    dwell_d = '0;
                end else if (dwell_q != '1) begin
                    dwell_d = dwell_q + DwellW'(1);
                end
                // Actuators follow the post-transition state.
                case (state_d)
                    StHeating: begin
                        if (sext(geo_q) > (gh + GeoDelta)) begin
                            geo_d_on = 1'b1;
                        end else begin
                            heater_d = 1'b1;
                        end
                    end
                    StCooling: begin
                        vent_d = 1'b1;
                        fan_d  = (sext(amb_q) >= gh);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            eval_q     <= 1'b0;
            solar_q    <= '0;
            gh_q       <= '0;
            amb_q      <= '0;
            geo_q      <= '0;
            n_lux_q    <= '0;
            e_lux_q    <= '0;
            s_lux_q    <= '0;
            w_lux_q    <= '0;
            state_q    <= StIdle;
            dwell_q    <= DwellMin;
            heater_q   <= 1'b0;
            geo_q_on   <= 1'b0;
            vent_q     <= 1'b0;
            fan_q      <= 1'b0;
            fault_q    <= 1'b0;
            solar_on_q <= 1'b0;
        end else begin
            cnt_q  <= tick ? '0 : cnt_q + CntW'(1);
            eval_q <= tick;
            if (tick) begin
                solar_q <= bus.solar_celcius;
                gh_q    <= bus.greenhouse_celcius;
                amb_q   <= bus.ambient_celcius;
                geo_q   <= bus.geothermal_celcius;
                n_lux_q <= bus.n_lux;
                e_lux_q <= bus.e_lux;
                s_lux_q <= bus.s_lux;
                w_lux_q <= bus.w_lux;
            end
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            heater_q   <= heater_d;
            geo_q_on   <= geo_d_on;
            vent_q     <= vent_d;
            fan_q      <= fan_d;
            fault_q    <= fault_d;
            solar_on_q <= solar_on_d;
        end
    end

    lux_shade_hyst #(
        .LUX_HI (LUX_HI),
        .LUX_LO (LUX_LO)
    ) u_lux_shade_hyst (
        .clk          (clk),
        .rst          (rst),
        .en           (eval_q),
        .n_lux        (n_lux_q),
        .e_lux        (e_lux_q),
        .s_lux        (s_lux_q),
        .w_lux        (w_lux_q),
        .shade_closed (shade)
    );

    assign bus.heater_on     = heater_q;
    assign bus.geo_pump_on   = geo_q_on;
    assign bus.vent_open     = vent_q;
    assign bus.fan_on        = fan_q;
    assign bus.shade_closed  = shade;
    assign bus.solar_pump_on = solar_on_q;
    assign bus.sensor_fault  = fault_q;
    assign bus.ctrl_state    = state_q;

endmodule

// File: tb/tb_greenhouse_climate_ctrl.sv
// Directed bench with a reference model feeding an expected-result queue.
module tb_greenhouse_climate_ctrl;

    localparam int unsigned SampleDiv = 4;
    localparam int          MinDwell  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    greenhouse_climate_ctrl_if bus ();

    greenhouse_climate_ctrl #(
        .SAMPLE_DIV (SampleDiv),
        .MIN_DWELL  (MinDwell)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int solar, gh, amb, geo;
    int lux [4];

    int         m_state;
    int         m_dwell;
    bit         m_shade;
    logic [8:0] prev_exp;
    logic [8:0] exp_q [$];
    bit         post_reset;

    // {heater, geo, vent, fan, shade, solar, fault, state[1:0]}
    function automatic logic [8:0] observed();
        return {bus.heater_on, bus.geo_pump_on, bus.vent_open, bus.fan_on, bus.shade_closed,
                bus.solar_pump_on, bus.sensor_fault, bus.ctrl_state};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.solar_celcius      = 9'(solar);
        bus.greenhouse_celcius = 9'(gh);
        bus.ambient_celcius    = 9'(amb);
        bus.geothermal_celcius = 9'(geo);
        bus.n_lux              = 16'(lux[0]);
        bus.e_lux              = 16'(lux[1]);
        bus.s_lux              = 16'(lux[2]);
        bus.w_lux              = 16'(lux[3]);
    endtask

    task automatic model_eval(output logic [8:0] e);
        bit f, h, g, v, fn, sp;
        int nxt, avg;
        f   = (gh < -40) || (gh > 85);
        sp  = (solar > gh + 5);
        avg = (lux[0] + lux[1] + lux[2] + lux[3]) / 4;
        if (avg > 30000) m_shade = 1'b1;
        else if (avg < 20000) m_shade = 1'b0;
        h = 0; g = 0; v = 0; fn = 0;
        if (f) begin
            m_state = 0;
            m_dwell = 0;
        end else begin
            nxt = m_state;
            if (m_dwell >= MinDwell) begin
                if (m_state == 0 && gh < 20) nxt = 1;
                else if (m_state == 0 && gh > 24) nxt = 2;
                else if (m_state == 1 && gh >= 22) nxt = 0;
                else if (m_state == 2 && gh <= 22) nxt = 0;
            end
            m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
            m_state = nxt;
            if (m_state == 1) begin
                if (geo > gh + 2) g = 1; else h = 1;
            end
            if (m_state == 2) begin
                v  = 1;
                fn = (amb >= gh);
            end
        end
        e = {h, g, v, fn, m_shade, sp, f, 2'(m_state)};
    endtask

    // Called #1 after an eval edge (or after reset release); ends #1 after the next eval edge.
    task automatic step(input string tag);
        logic [8:0] e;
        int n;
        drive();
        model_eval(e);
        exp_q.push_back(e);
        n = int'(SampleDiv) + (post_reset ? 1 : 0);
        repeat (n - 1) @(posedge clk);
        #1;
        check({tag, "_hold"}, observed(), prev_exp);
        @(posedge clk);
        #1;
        check(tag, observed(), exp_q.pop_front());
        prev_exp   = e;
        post_reset = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("reset_outputs", observed(), 9'd0);
        rst        = 1'b1;
        m_state    = 0;
        m_dwell    = MinDwell;
        m_shade    = 1'b0;
        prev_exp   = '0;
        post_reset = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        solar = 0; gh = 22; amb = 22; geo = 0;
        lux = '{1000, 1000, 1000, 1000};
        drive();
        do_reset(2);

        // 1: quiet idle
        for (int i = 0; i < 5; i++) begin
            step("t1_idle");
            check("t1_quiet", observed(), 9'd0);
        end

        // 2: heating, geothermal preference, dwell before returning to idle
        gh = 18;
        step("t2_heat");
        check("t2_heater", 9'(bus.heater_on), 9'd1);
        check("t2_state", 9'(bus.ctrl_state), 9'd1);
        geo = 25;
        step("t2_geo");
        check("t2_geo_on", 9'(bus.geo_pump_on), 9'd1);
        check("t2_heater_off", 9'(bus.heater_on), 9'd0);
        gh = 22;
        step("t2_dwell");
        check("t2_still_heat", 9'(bus.ctrl_state), 9'd1);
        step("t2_idle");
        check("t2_back_idle", 9'(bus.ctrl_state), 9'd0);
        check("t2_geo_off", 9'(bus.geo_pump_on), 9'd0);

        // 3: cooling, fan on ambient, no direct cool->heat
        gh = 26; amb = 15;
        step("t3_wait1");
        step("t3_wait2");
        step("t3_cool");
        check("t3_state", 9'(bus.ctrl_state), 9'd2);
        check("t3_vent", 9'(bus.vent_open), 9'd1);
        check("t3_fan_off", 9'(bus.fan_on), 9'd0);
        amb = 30;
        step("t3_fan");
        check("t3_fan_on", 9'(bus.fan_on), 9'd1);
        gh = 10;
        step("t3_hold_cool");
        check("t3_hold_state", 9'(bus.ctrl_state), 9'd2);
        step("t3_to_idle");
        check("t3_idle_not_heat", 9'(bus.ctrl_state), 9'd0);
        step("t3_idle_dw1");
        check("t3_idle_dw1_state", 9'(bus.ctrl_state), 9'd0);
        step("t3_idle_dw2");
        check("t3_idle_dw2_state", 9'(bus.ctrl_state), 9'd0);
        step("t3_heat");
        check("t3_heat_state", 9'(bus.ctrl_state), 9'd1);

        // 4: shade hysteresis and full-scale average
        foreach (lux[i]) lux[i] = 35000;
        step("t4_bright");
        check("t4_shade_close", 9'(bus.shade_closed), 9'd1);
        foreach (lux[i]) lux[i] = 25000;
        step("t4_band");
        check("t4_shade_hold", 9'(bus.shade_closed), 9'd1);
        foreach (lux[i]) lux[i] = 15000;
        step("t4_dim");
        check("t4_shade_open", 9'(bus.shade_closed), 9'd0);
        foreach (lux[i]) lux[i] = 65535;
        step("t4_full");
        check("t4_shade_full", 9'(bus.shade_closed), 9'd1);

        // 5: sensor fault gating, range boundaries, solar pump independent of fault
        gh = -256; solar = 40;
        step("t5_fault");
        check("t5_fault_set", 9'(bus.sensor_fault), 9'd1);
        check("t5_fault_idle", 9'(bus.ctrl_state), 9'd0);
        check("t5_fault_heater", 9'(bus.heater_on), 9'd0);
        check("t5_fault_solar", 9'(bus.solar_pump_on), 9'd1);
        gh = 20;
        step("t5_clear");
        check("t5_fault_clear", 9'(bus.sensor_fault), 9'd0);
        gh = 30;
        step("t5_solar");
        check("t5_solar_on", 9'(bus.solar_pump_on), 9'd1);
        gh = 86;
        step("t5_over");
        check("t5_over_fault", 9'(bus.sensor_fault), 9'd1);
        gh = 85;
        step("t5_max");
        check("t5_max_ok", 9'(bus.sensor_fault), 9'd0);
        gh = -41;
        step("t5_under");
        check("t5_under_fault", 9'(bus.sensor_fault), 9'd1);
        gh = -40;
        step("t5_min");
        check("t5_min_ok", 9'(bus.sensor_fault), 9'd0);

        // 6: reset while cooling, then prescaler restarts from zero
        gh = 30; amb = 15;
        step("t6_wait");
        step("t6_cool");
        check("t6_vent", 9'(bus.vent_open), 9'd1);
        do_reset(1);
        step("t6_restart");
        check("t6_restart_state", 9'(bus.ctrl_state), 9'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
